mem_stage: RTL and testbench

Memory-access stage of the 5-stage pipeline: it sits between the execute stage and the write-back stage. It consumes the EX/MEM fields and performs load/store accesses to data memory over a req/ack handshake, stalling upstream while waiting. It produces the registered MEM/WB fields (valid, write enable, destination register, result) that write-back commits to the register file. It also flags misaligned accesses and memory timeouts.

---
 rtl/mem_stage_if.sv | 11 +
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the memory stage and data memory
interface mem_stage_if #(parameter int SIZE = 32) ();
    logic            req;
    logic            we;
    logic [SIZE-1:0] addr;
    logic [SIZE-1:0] wdata;
    logic [SIZE-1:0] rdata;
    logic            ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with req/ack data memory, misalign and timeout faults
module mem_stage #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ex_valid,
    input  logic                    ex_mem_read,
    input  logic                    ex_mem_write,
    input  logic                    ex_reg_write,
    input  logic                    ex_mem_to_reg,
    input  logic [$clog2(SIZE)-1:0] ex_write_reg,
    input  logic [SIZE-1:0]         ex_alu_result,
    input  logic [SIZE-1:0]         ex_store_data,
    output logic                    stall,
    mem_stage_if.master             dmem,
    output logic                    wb_valid,
    output logic                    wb_reg_write,
    output logic [$clog2(SIZE)-1:0] wb_write_reg,
    output logic [SIZE-1:0]         wb_data,
    output logic                    misalign,
    output logic                    bus_error
);
    localparam int RW = $clog2(SIZE);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            req_n, we_n;
    logic [SIZE-1:0] addr_n, wdata_n;
    logic [RW-1:0]   l_wreg, l_wreg_n;
    logic            l_rw, l_rw_n, l_m2r, l_m2r_n;
    logic            wb_valid_n, wb_rw_n, mis_n, berr_n;
    logic [RW-1:0]   wb_wreg_n;
    logic [SIZE-1:0] wb_data_n;
    logic            mem_op, mis, hit;

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign mis    = |(ex_alu_result & SIZE'(SIZE / 8 - 1));
    assign hit    = cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            l_wreg       <= '0;
            l_rw         <= 1'b0;
            l_m2r        <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_write_reg <= '0;
            wb_data      <= '0;
            misalign     <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dmem.req     <= req_n;
            dmem.we      <= we_n;
            dmem.addr    <= addr_n;
            dmem.wdata   <= wdata_n;
            l_wreg       <= l_wreg_n;
            l_rw         <= l_rw_n;
            l_m2r        <= l_m2r_n;
            wb_valid     <= wb_valid_n;
            wb_reg_write <= wb_rw_n;
            wb_write_reg <= wb_wreg_n;
            wb_data      <= wb_data_n;
            misalign     <= mis_n;
            bus_error    <= berr_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        req_n      = dmem.req;
        we_n       = dmem.we;
        addr_n     = dmem.addr;
        wdata_n    = dmem.wdata;
        l_wreg_n   = l_wreg;
        l_rw_n     = l_rw;
        l_m2r_n    = l_m2r;
        wb_valid_n = 1'b0;
        wb_rw_n    = 1'b0;
        wb_wreg_n  = wb_write_reg;
        wb_data_n  = wb_data;
        mis_n      = 1'b0;
        berr_n     = 1'b0;
        stall      = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            if (mem_op && !mis) begin
                stall    = 1'b1;
                state_n  = WAIT;
                req_n    = 1'b1;
                we_n     = ex_mem_write;
                addr_n   = ex_alu_result;
                wdata_n  = ex_store_data;
                l_wreg_n = ex_write_reg;
                l_rw_n   = ex_reg_write;
                l_m2r_n  = ex_mem_to_reg;
            end else begin
                // a misaligned memory op passes through as a faulted, non-writing entry
                wb_valid_n = ex_valid;
                wb_rw_n    = ex_valid & ex_reg_write & ~mem_op & (ex_write_reg != '0);
                wb_wreg_n  = ex_write_reg;
                wb_data_n  = ex_alu_result;
                mis_n      = mem_op;
            end
        end else if (dmem.ack || hit) begin
            // ack takes priority over a timeout reached in the same cycle
            state_n    = IDLE;
            req_n      = 1'b0;
            wb_valid_n = 1'b1;
            wb_rw_n    = dmem.ack & l_rw & (l_wreg != '0);
            wb_wreg_n  = l_wreg;
            wb_data_n  = (dmem.ack && l_m2r) ? dmem.rdata : dmem.addr;
            berr_n     = ~dmem.ack;
        end else begin
            stall = 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a queued scoreboard checked by a write-back monitor
module tb_mem_stage;
    localparam int SIZE = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        logic        chk;
    } exp_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        ex_valid = 0, ex_mem_read = 0, ex_mem_write = 0, ex_reg_write = 0, ex_mem_to_reg = 0;
    logic [4:0]  ex_write_reg = '0;
    logic [31:0] ex_alu_result = '0, ex_store_data = '0;
    logic        stall, wb_valid, wb_reg_write, misalign, bus_error;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    int          checks = 0, errors = 0;
    exp_t        q[$];
    exp_t        e;
    int          reqc, stallc;
    bit          bus_ok;

    mem_stage_if #(.SIZE(SIZE)) dmem ();

    mem_stage #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .stall(stall), .dmem(dmem),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .misalign(misalign), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [4:0] wreg, input logic [31:0] data,
                        input logic mis, input logic berr, input logic c);
        exp_t x;
        x.rw = rw; x.wreg = wreg; x.data = data; x.mis = mis; x.berr = berr; x.chk = c;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb: got data %h with empty queue", wb_data);
                end else begin
                    e = q.pop_front();
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                    chk("misalign", 32'(misalign), 32'(e.mis));
                    chk("bus_error", 32'(bus_error), 32'(e.berr));
                    if (e.chk) begin
                        chk("wb_write_reg", 32'(wb_write_reg), 32'(e.wreg));
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else if (misalign || bus_error) begin
                chk("fault_without_valid", {30'd0, misalign, bus_error}, 32'd0);
            end
        end
    end

    task automatic present(input logic rd, input logic wr, input logic rw,
                           input logic [4:0] wreg, input logic [31:0] a);
        ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
        ex_mem_to_reg = rd; ex_write_reg = wreg; ex_alu_result = a;
        @(negedge clk);
        chk("present_stall", 32'(stall), 32'd0);
        chk("present_req", 32'(dmem.req), 32'd0);
        @(posedge clk); #1;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    endtask

    task automatic do_mem(input logic wr, input logic rw, input logic m2r, input logic [4:0] wreg,
                          input logic [31:0] a, input logic [31:0] sd, input int k,
                          input logic [31:0] rdv, output int rc, output int sc, output bit ok);
        logic s;
        ex_valid = 1; ex_mem_read = !wr; ex_mem_write = wr; ex_reg_write = rw;
        ex_mem_to_reg = m2r; ex_write_reg = wreg; ex_alu_result = a; ex_store_data = sd;
        rc = 0; sc = 0; ok = 1;
        for (int c = 0; c <= TIMEOUT + 2; c++) begin
            if (k > 0 && c == k) begin
                dmem.ack = 1; dmem.rdata = rdv;
            end
            @(negedge clk);
            if (dmem.req) begin
                rc++;
                if (dmem.addr !== a || dmem.we !== wr || (wr && dmem.wdata !== sd)) ok = 0;
            end
            s = stall;
            if (s) sc++;
            @(posedge clk); #1;
            dmem.ack = 0;
            if (!s) break;
        end
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem.ack = 0; dmem.rdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ctrl", {24'd0, stall, dmem.req, dmem.we, wb_valid, wb_reg_write, misalign, bus_error, 1'b0}, 32'd0);
        chk("reset_addr", dmem.addr | dmem.wdata, 32'd0);
        chk("reset_wb", wb_data | 32'(wb_write_reg), 32'd0);
        @(posedge clk); #1;
        reset = 0;

        push(1, 5, 32'h1234, 0, 0, 1);
        present(0, 0, 1, 5, 32'h1234);

        push(1, 3, 32'hDEADBEEF, 0, 0, 1);
        do_mem(0, 1, 1, 3, 32'h40, 0, 3, 32'hDEADBEEF, reqc, stallc, bus_ok);
        chk("load_req_cycles", reqc, 3);
        chk("load_stall_cycles", stallc, 3);
        chk("load_addr_stable", 32'(bus_ok), 1);

        push(0, 9, 32'h10, 0, 0, 1);
        do_mem(1, 0, 0, 9, 32'h10, 32'hA5A5A5A5, 1, 0, reqc, stallc, bus_ok);
        chk("store_req_cycles", reqc, 1);
        chk("store_bus", 32'(bus_ok), 1);

        push(0, 4, 0, 1, 0, 0);
        present(1, 0, 1, 4, 32'h42);

        push(0, 6, 0, 0, 1, 0);
        do_mem(0, 1, 1, 6, 32'h80, 0, 0, 0, reqc, stallc, bus_ok);
        chk("timeout_req_cycles", reqc, TIMEOUT);
        chk("timeout_stall_cycles", stallc, TIMEOUT);

        push(1, 7, 32'h0BADF00D, 0, 0, 1);
        do_mem(0, 1, 1, 7, 32'h84, 0, TIMEOUT, 32'h0BADF00D, reqc, stallc, bus_ok);
        chk("lastack_req_cycles", reqc, TIMEOUT);

        push(0, 0, 32'h55, 0, 0, 1);
        present(0, 0, 1, 0, 32'h55);

        push(1, 1, 32'h11111111, 0, 0, 1);
        do_mem(0, 1, 1, 1, 32'h100, 0, 1, 32'h11111111, reqc, stallc, bus_ok);
        push(1, 2, 32'h104, 0, 0, 1);
        do_mem(0, 1, 0, 2, 32'h104, 0, 2, 32'h22222222, reqc, stallc, bus_ok);
        chk("b2b_req_cycles", reqc, 2);

        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
        ex_write_reg = 8; ex_alu_result = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ex_valid = 0; ex_mem_read = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rst_wait_req", 32'(dmem.req), 0);
        chk("rst_wait_valid", 32'(wb_valid), 0);
        @(posedge clk); #1;
        dmem.ack = 1; dmem.rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        dmem.ack = 0;
        @(negedge clk);
        chk("stale_ack_valid", 32'(wb_valid), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
